icache_miss_req_arbiter: RTL

//  Shares the single ICache downstream (L2/bus) request channel between two sources: demand misses from
//  the MSHR and next-line prefetches from icache_prefetch_engine. Demand has priority, with anti-starvation.

---
 rtl/icache_miss_req_arbiter_if.sv | 44 ++++
 rtl/icache_miss_req_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_miss_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// icache_miss_req_arbiter_pkg / icache_miss_req_arbiter_if
//
// Purpose:
//   Shared request payload type for the ICache downstream request path, and
//   a valid/ready request channel interface used for three channels:
//   demand misses, prefetches and the downstream (L2/bus) request.
//
// Interface signals:
//   vld  valid, driven by the producer
//   pld  pc_req_t payload (addr / txnid / opcode), driven by the producer
//   rdy  ready, driven by the consumer; a transfer happens when vld & rdy
//
// Modports:
//   master  producer side (drives vld/pld, samples rdy)
//   slave   consumer side (samples vld/pld, drives rdy)
// -----------------------------------------------------------------------------
package icache_miss_req_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int TXNID_W  = 8;
  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] DEMAND_OPCODE   = 4'h1;
  localparam logic [OPCODE_W-1:0] PREFETCH_OPCODE = 4'h2;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [TXNID_W-1:0]  txnid;
    logic [OPCODE_W-1:0] opcode;
  } pc_req_t;

endpackage

interface icache_miss_req_arbiter_if;

  logic                                 vld;
  icache_miss_req_arbiter_pkg::pc_req_t pld;
  logic                                 rdy;

  modport master (output vld, output pld, input rdy);
  modport slave  (input vld, input pld, output rdy);

endinterface

// File: rtl/icache_miss_req_arbiter.sv
// -----------------------------------------------------------------------------
// icache_miss_req_arbiter
//
// Purpose:
//   Shares the single ICache downstream request channel between demand misses
//   (from the MSHR) and next-line prefetches. Demand wins by default; a
//   prefetch that has been passed over STARVE_LIMIT consecutive times while
//   eligible is forced through. Outstanding downstream transactions are
//   limited by a credit counter, and prefetches must leave PREF_RESERVE
//   credits untouched so that demand always has headroom. Prefetches that
//   target the same line as the current or most recent demand are dropped.
//   The downstream request is registered (one cycle of latency).
//
// Ports:
//   clk            clock
//   rst_n          asynchronous active-low reset
//   demand_req     slave channel: MSHR demand misses
//   pref_req       slave channel: prefetch engine requests (consumed when
//                  forwarded or dropped)
//   pref_enable    0: every prefetch is consumed and dropped
//   down_req       master channel: registered downstream request
//   down_rsp_vld   one downstream transaction completed (returns a credit)
//   credit_cnt     credits currently available
//   pref_drop_cnt  saturating count of line-duplicate prefetch drops
//   credit_err     sticky: credit returned while the counter was already full
// -----------------------------------------------------------------------------
module icache_miss_req_arbiter
  import icache_miss_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int PREF_RESERVE    = 1,
  parameter int STARVE_LIMIT    = 4,
  parameter int LINE_OFFSET_W   = 6,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  icache_miss_req_arbiter_if.slave         demand_req,
  icache_miss_req_arbiter_if.slave         pref_req,
  input  logic                             pref_enable,
  icache_miss_req_arbiter_if.master        down_req,
  input  logic                             down_rsp_vld,
  output logic [CW-1:0]                    credit_cnt,
  output logic [15:0]                      pref_drop_cnt,
  output logic                             credit_err
);

  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam int LINE_W = ADDR_W - LINE_OFFSET_W;

  localparam logic [CW-1:0] MAX_CREDITS  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] PREF_RSV     = CW'(PREF_RESERVE);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              down_vld_reg;
  pc_req_t           down_pld_reg;
  logic [CW-1:0]     credit_reg;
  logic [SW-1:0]     starve_reg;
  logic [15:0]       drop_cnt_reg;
  logic              credit_err_reg;
  logic [LINE_W-1:0] last_line_reg;
  logic              last_line_vld_reg;

  // ---------------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------------
  logic              out_free;
  logic [LINE_W-1:0] dem_line;
  logic [LINE_W-1:0] pref_line;
  logic              dup;
  logic              dem_ok;
  logic              pref_ok;
  logic              force_pref;
  logic              grant_pref;
  logic              grant_dem;
  logic              grant_any;
  logic              drop_dup;
  logic              drop_dis;

  // The output register can take a new request when it is empty or is being
  // emptied this very cycle.
  assign out_free = !down_vld_reg || down_req.rdy;

  assign dem_line  = demand_req.pld.addr[ADDR_W-1:LINE_OFFSET_W];
  assign pref_line = pref_req.pld.addr[ADDR_W-1:LINE_OFFSET_W];

  // A prefetch is redundant if demand is fetching (or just fetched) its line.
  // The comparison against the live demand uses demand valid, not demand
  // grant, so a stalled demand still suppresses its matching prefetch.
  assign dup = (demand_req.vld && (pref_line == dem_line)) ||
               (last_line_vld_reg && (pref_line == last_line_reg));

  assign dem_ok  = demand_req.vld && out_free && (credit_reg != '0);
  assign pref_ok = pref_req.vld && pref_enable && !dup && out_free &&
                   (credit_reg > PREF_RSV);

  assign force_pref = (starve_reg == STARVE_MAX);

  assign grant_pref = pref_ok && (force_pref || !dem_ok);
  assign grant_dem  = dem_ok && !grant_pref;
  assign grant_any  = grant_pref || grant_dem;

  // Drops never need an output slot or a credit.
  assign drop_dup = pref_req.vld && pref_enable && dup;
  assign drop_dis = pref_req.vld && !pref_enable;

  // Ready outputs are held low while reset is asserted; the state is frozen
  // during reset so nothing could legally be accepted anyway.
  assign demand_req.rdy = rst_n && grant_dem;
  assign pref_req.rdy   = rst_n && (grant_pref || drop_dup || drop_dis);

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      down_vld_reg <= 1'b0;
      down_pld_reg <= '0;
    end else if (grant_pref) begin
      down_vld_reg <= 1'b1;
      down_pld_reg <= pref_req.pld;
    end else if (grant_dem) begin
      down_vld_reg <= 1'b1;
      down_pld_reg <= demand_req.pld;
    end else if (down_req.rdy) begin
      // Payload is left as-is; only valid drops once the beat is taken.
      down_vld_reg <= 1'b0;
    end
  end

  assign down_req.vld = down_vld_reg;
  assign down_req.pld = down_pld_reg;

  // ---------------------------------------------------------------------------
  // Last granted demand line (prefetch duplicate filter)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_line_reg     <= '0;
      last_line_vld_reg <= 1'b0;
    end else if (grant_dem) begin
      last_line_reg     <= dem_line;
      last_line_vld_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Credits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_reg     <= MAX_CREDITS;
      credit_err_reg <= 1'b0;
    end else begin
      unique case ({grant_any, down_rsp_vld})
        2'b10: credit_reg <= credit_reg - 1'b1;
        2'b01: begin
          // A return with nothing outstanding is a protocol error upstream;
          // the count is clamped rather than allowed to overflow.
          if (credit_reg == MAX_CREDITS) begin
            credit_err_reg <= 1'b1;
          end else begin
            credit_reg <= credit_reg + 1'b1;
          end
        end
        default: ; // idle, or grant and return cancel out
      endcase
    end
  end

  assign credit_cnt = credit_reg;
  assign credit_err = credit_err_reg;

  // ---------------------------------------------------------------------------
  // Anti-starvation counter
  // ---------------------------------------------------------------------------
  // Counts consecutive cycles where an eligible prefetch lost to demand.
  // Any prefetch consumption or a gap in prefetch valid restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
    end else if (!pref_req.vld || grant_pref || drop_dup || drop_dis) begin
      starve_reg <= '0;
    end else if (pref_ok && grant_dem && (starve_reg != STARVE_MAX)) begin
      starve_reg <= starve_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Duplicate drop counter (pref_enable=0 drops are intentionally excluded)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (drop_dup && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign pref_drop_cnt = drop_cnt_reg;

endmodule
